fifo_arb_ctrl: RTL and testbench

FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/fifo_arb_ctrl.sv | 139 +++++++++++++
 tb/tb_fifo_arb_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and read-side occupancy states for fifo_arb_ctrl.
package fifo_arb_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF   = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   function automatic logic [1:0] occ_level(input occ_e s);
      logic [1:0] lvl;
      case (s)
         EMPTY:   lvl = 2'd0;
         ONE:     lvl = 2'd1;
         TWO:     lvl = 2'd2;
         default: lvl = 2'd0;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o
);
   localparam int SUM_W = PTR_W + 1;

   logic             found_s;
   logic [SUM_W-1:0] raw_s;
   logic [SUM_W-1:0] sum_s;
   logic [PTR_W-1:0] idx_s;

   // Scan upward from the pointer, wrapping modulo NUM_REQ; the first requester wins.
   always_comb begin
      gnt_o   = '0;
      found_s = 1'b0;
      raw_s   = '0;
      sum_s   = '0;
      idx_s   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         raw_s        = {1'b0, ptr_i} + SUM_W'(i);
         sum_s        = (raw_s >= SUM_W'(NUM_REQ)) ? (raw_s - SUM_W'(NUM_REQ)) : raw_s;
         idx_s        = sum_s[PTR_W-1:0];
         gnt_o[idx_s] = gnt_o[idx_s] | (req_i[idx_s] & ~found_s);
         found_s      = found_s | req_i[idx_s];
      end
   end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Round-robin multi-writer front end and 2-entry prefetching read buffer around an external FIFO.
module fifo_arb_ctrl
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic                     fifo_wr_en_o,
   output logic [WIDTH-1:0]         fifo_wdata_o,
   input  logic                     fifo_full_i,
   input  logic                     fifo_empty_i,
   output logic                     fifo_rd_en_o,
   input  logic [WIDTH-1:0]         fifo_rdata_i,
   output logic                     m_valid_o,
   output logic [WIDTH-1:0]         m_data_o,
   input  logic                     m_ready_i,
   output logic [CNT_W-1:0]         stall_cnt_o
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   ptr_d, ptr_q;
   logic [NUM_REQ-1:0] req_eff_s, gnt_s;
   logic [WIDTH-1:0]   wdata_s;
   logic [CNT_W-1:0]   stall_d, stall_q;
   occ_e               occ_d, occ_q;
   logic               inflight_d, inflight_q;
   logic [WIDTH-1:0]   buf0_d, buf0_q, buf1_d, buf1_q;
   logic               pop_s, push_s, rd_en_s;
   logic [1:0]         level_s;

   // Grants are suppressed in reset as well as when the FIFO is full.
   assign req_eff_s = (rst_ni && !fifo_full_i) ? req_i : '0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req_i (req_eff_s),
      .ptr_i (ptr_q),
      .gnt_o (gnt_s)
   );

   // Write data mux, pointer advance and saturating stall counter.
   always_comb begin
      wdata_s = '0;
      ptr_d   = ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         wdata_s = wdata_s | (wdata_i[k*WIDTH +: WIDTH] & {WIDTH{gnt_s[k]}});
         ptr_d   = gnt_s[k] ? ((k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1)) : ptr_d;
      end
      if ((|req_i) && fifo_full_i && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   // Prefetch only while buffered plus in-flight words, net of this cycle's pop, leave room.
   always_comb begin
      pop_s   = (occ_q != EMPTY) && m_ready_i;
      push_s  = inflight_q;
      level_s = occ_level(occ_q) + {1'b0, inflight_q} - {1'b0, pop_s};
      rd_en_s = rst_ni && !fifo_empty_i && (level_s < 2'd2);
   end

   // Occupancy FSM next state; buf0 always holds the oldest word.
   always_comb begin
      occ_d  = occ_q;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      case (occ_q)
         EMPTY: begin
            if (push_s) begin
               occ_d  = ONE;
               buf0_d = fifo_rdata_i;
            end else begin
               occ_d = EMPTY;
            end
         end
         ONE: begin
            if (push_s && pop_s) begin
               buf0_d = fifo_rdata_i;
            end else if (push_s) begin
               occ_d  = TWO;
               buf1_d = fifo_rdata_i;
            end else if (pop_s) begin
               occ_d = EMPTY;
            end else begin
               occ_d = ONE;
            end
         end
         TWO: begin
            if (pop_s) begin
               occ_d  = push_s ? TWO : ONE;
               buf0_d = buf1_q;
               buf1_d = push_s ? fifo_rdata_i : buf1_q;
            end else begin
               occ_d = TWO;
            end
         end
         default: occ_d = EMPTY;
      endcase
      inflight_d = rd_en_s;
   end

   // State registers; reset drops buffered and in-flight words.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         stall_q    <= '0;
         occ_q      <= EMPTY;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         ptr_q      <= ptr_d;
         stall_q    <= stall_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

   assign gnt_o        = gnt_s;
   assign fifo_wr_en_o = |gnt_s;
   assign fifo_wdata_o = wdata_s;
   assign fifo_rd_en_o = rd_en_s;
   assign m_valid_o    = (occ_q != EMPTY);
   assign m_data_o     = buf0_q;
   assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Randomised + directed bench for fifo_arb_ctrl against a queue-based reference model.
`timescale 1ns/1ps
module tb_fifo_arb_ctrl;
   localparam int W         = 8;
   localparam int N         = 4;
   localparam int CW        = 6;
   localparam int STALL_MAX = (1 << CW) - 1;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic [N-1:0]   req_i;
   logic [N*W-1:0] wdata_i;
   logic [N-1:0]   gnt_o;
   logic           fifo_wr_en_o;
   logic [W-1:0]   fifo_wdata_o;
   logic           fifo_full_i;
   logic           fifo_empty_i;
   logic           fifo_rd_en_o;
   logic [W-1:0]   fifo_rdata_i;
   logic           m_valid_o;
   logic [W-1:0]   m_data_o;
   logic           m_ready_i;
   logic [CW-1:0]  stall_cnt_o;

   always #5 clk_i = ~clk_i;

   fifo_arb_ctrl #(.WIDTH(W), .NUM_REQ(N), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
      .fifo_wr_en_o(fifo_wr_en_o), .fifo_wdata_o(fifo_wdata_o), .fifo_full_i(fifo_full_i),
      .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o), .fifo_rdata_i(fifo_rdata_i),
      .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i), .stall_cnt_o(stall_cnt_o)
   );

   int n_vec = 0;
   int n_chk = 0;
   int n_err = 0;

   // Reference model: pointer, stall count, the external FIFO contents, the output buffer
   // as a queue of words, and the word currently travelling back from the FIFO.
   int           m_ptr;
   int           m_stall;
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] mbuf[$];
   bit           m_inf;
   logic [W-1:0] m_inf_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt_o),        32'd0);
      chk({tag, "_wren"},  32'(fifo_wr_en_o), 32'd0);
      chk({tag, "_wdata"}, 32'(fifo_wdata_o), 32'd0);
      chk({tag, "_rden"},  32'(fifo_rd_en_o), 32'd0);
      chk({tag, "_valid"}, 32'(m_valid_o),    32'd0);
      chk({tag, "_data"},  32'(m_data_o),     32'd0);
      chk({tag, "_stall"}, 32'(stall_cnt_o),  32'd0);
   endtask

   // Asserts reset at once (mid-cycle), checks outputs, then releases away from the edge.
   task automatic do_reset(input int cyc);
      #1;
      rst_ni = 1'b0; req_i = '1; fifo_full_i = 1'b0; fifo_empty_i = 1'b0; m_ready_i = 1'b1;
      #1;
      chk_zero("rst_async");
      for (int c = 0; c < cyc; c++) begin
         @(negedge clk_i);
         chk_zero("rst_hold");
         n_vec++;
      end
      @(posedge clk_i); #1;
      req_i = '0; fifo_empty_i = 1'b1;
      rst_ni = 1'b1;
      m_ptr = 0; m_stall = 0; m_inf = 1'b0;
      mbuf.delete(); fifo_q.delete();
   endtask

   // One clock cycle: drive inputs after the edge, compare at the falling edge, advance the model.
   task automatic step(input logic [N-1:0] req, input logic [N*W-1:0] wd, input logic full,
                       input logic rdy);
      logic [N-1:0] e_gnt;
      logic [W-1:0] e_wd;
      logic [W-1:0] e_data;
      logic         e_valid, e_pop, e_rd;
      int           gk, k, lvl;
      @(posedge clk_i); #1;
      req_i = req; wdata_i = wd; fifo_full_i = full; m_ready_i = rdy;
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_rdata_i = m_inf ? m_inf_data : W'($urandom);
      @(negedge clk_i);
      e_gnt = '0; e_wd = '0; gk = -1;
      if (!full) begin
         for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (gk < 0 && req[k]) gk = k;
         end
      end
      if (gk >= 0) begin
         e_gnt[gk] = 1'b1;
         e_wd = W'(wd >> (gk * W));
      end
      e_valid = (mbuf.size() > 0);
      e_data  = e_valid ? mbuf[0] : '0;
      e_pop   = e_valid && rdy;
      lvl     = mbuf.size() + int'(m_inf) - int'(e_pop);
      e_rd    = (fifo_q.size() > 0) && (lvl < 2);
      chk("gnt",   32'(gnt_o),        32'(e_gnt));
      chk("wr_en", 32'(fifo_wr_en_o), 32'(gk >= 0));
      chk("wdata", 32'(fifo_wdata_o), 32'(e_wd));
      chk("stall", 32'(stall_cnt_o),  32'(m_stall));
      chk("rd_en", 32'(fifo_rd_en_o), 32'(e_rd));
      chk("valid", 32'(m_valid_o),    32'(e_valid));
      if (e_valid) chk("m_data", 32'(m_data_o), 32'(e_data));
      if (e_pop) void'(mbuf.pop_front());
      if (m_inf) mbuf.push_back(m_inf_data);
      m_inf = e_rd;
      if (e_rd) m_inf_data = fifo_q.pop_front();
      if (gk >= 0) begin
         fifo_q.push_back(e_wd);
         m_ptr = (gk + 1) % N;
      end
      if (req != '0 && full && m_stall < STALL_MAX) m_stall++;
      n_vec++;
   endtask

   logic [N-1:0]   g_lit [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [W-1:0]   d_lit [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
   logic [W-1:0]   a_lit [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
   logic [N*W-1:0] wd_fix;
   int             rd_cnt;

   initial begin
      rst_ni = 1'b0; req_i = '0; wdata_i = '0; fifo_full_i = 1'b0; fifo_empty_i = 1'b1;
      fifo_rdata_i = '0; m_ready_i = 1'b0;
      do_reset(3);

      // All four writers request: rotating grants and matching slices.
      wd_fix = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, wd_fix, 1'b0, 1'b1);
         chk("rr_gnt_lit",   32'(gnt_o),        32'(g_lit[i]));
         chk("rr_wdata_lit", 32'(fifo_wdata_o), 32'(d_lit[i]));
      end

      // Full for five cycles: nothing granted, counter +5, pointer held at 1.
      for (int i = 0; i < 5; i++) begin
         step(4'b0101, wd_fix, 1'b1, 1'b1);
         chk("full_gnt_lit", 32'(gnt_o),        32'd0);
         chk("full_wr_lit",  32'(fifo_wr_en_o), 32'd0);
      end
      step(4'b0101, wd_fix, 1'b0, 1'b1);
      chk("full_stall_lit", 32'(stall_cnt_o), 32'd5);
      chk("full_ptr_lit",   32'(gnt_o),       32'b0100);

      // Preloaded 11,22,33 with ready high: first valid two cycles after the first read.
      do_reset(1);
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
      step('0, '0, 1'b0, 1'b1); chk("lat_rd0", 32'(fifo_rd_en_o), 32'd1); chk("lat_v0", 32'(m_valid_o), 32'd0);
      step('0, '0, 1'b0, 1'b1); chk("lat_v1", 32'(m_valid_o), 32'd0);
      step('0, '0, 1'b0, 1'b1); chk("lat_d2", 32'(m_data_o), 32'h11); chk("lat_v2", 32'(m_valid_o), 32'd1);
      step('0, '0, 1'b0, 1'b1); chk("lat_d3", 32'(m_data_o), 32'h22); chk("lat_v3", 32'(m_valid_o), 32'd1);
      step('0, '0, 1'b0, 1'b1); chk("lat_d4", 32'(m_data_o), 32'h33); chk("lat_v4", 32'(m_valid_o), 32'd1);
      step('0, '0, 1'b0, 1'b1); chk("lat_v5", 32'(m_valid_o), 32'd0);

      // Consumer stalled: exactly two reads, stable head, then in-order drain.
      for (int i = 0; i < 4; i++) fifo_q.push_back(a_lit[i]);
      rd_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step('0, '0, 1'b0, 1'b0);
         rd_cnt += int'(fifo_rd_en_o);
         if (i >= 2) chk("bp_hold_lit", 32'(m_data_o), 32'hA1);
      end
      chk("bp_reads_lit", 32'(rd_cnt), 32'd2);
      for (int i = 0; i < 4; i++) begin
         step('0, '0, 1'b0, 1'b1);
         chk("bp_drain_lit", 32'(m_data_o), 32'(a_lit[i]));
      end

      // Reset with a word buffered and another in flight: nothing survives.
      do_reset(1);
      fifo_q.push_back(8'hB1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hB3);
      for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b0);
      do_reset(2);
      for (int i = 0; i < 3; i++) begin
         step('0, '0, 1'b0, 1'b1);
         chk("rst_flush_lit", 32'(m_valid_o), 32'd0);
      end
      fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2);
      for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b1);
      chk("rst_new_lit", 32'(m_data_o), 32'hC1);
      step('0, '0, 1'b0, 1'b1);
      chk("rst_new2_lit", 32'(m_data_o), 32'hC2);

      // Counter saturation with full held.
      do_reset(1);
      for (int i = 0; i < STALL_MAX + 3; i++) begin
         step(4'b0101, wd_fix, 1'b1, 1'b1);
         if (i == 9) chk("sat_mid_lit", 32'(stall_cnt_o), 32'd9);
      end
      chk("sat_top_lit", 32'(stall_cnt_o), 32'(STALL_MAX));

      // Random traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) do_reset(2);
         step(N'($urandom), ($urandom),
              (fifo_q.size() >= 6) || ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
